bitstuff_gen: RTL
=================

BITSTUFF_GEN -- requirements
Module: bitstuff_gen

Parameters
REQ-001 RUN_LEN, default 6, number of consecutive 1s that triggers a stuff or destuff event; legal range 2..15.
REQ-002 DEPTH, default 16, number of FIFO entries; must be a power of 2, at least 4.
REQ-003 PTYPE_W, default 2, width of the packet-type tag carried with each bit.

Interface
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  0 = stuff (insert 0 after each run), 1 = destuff (remove the 0 after each run).
REQ-007 flush  in  1  synchronous clear of the FIFO, run counter and pending stuff.
REQ-008 in_bit  in  1  serial data bit.
REQ-009 in_ptype  in  PTYPE_W  packet-type tag for in_bit.
REQ-010 in_valid  in  1  in_bit and in_ptype are valid.
REQ-011 in_ready  out  1  block can accept a bit; equals ~full.
REQ-012 out_bit  out  1  serial output bit.
REQ-013 out_ptype  out  PTYPE_W  tag for out_bit.
REQ-014 out_valid  out  1  out_bit and out_ptype are valid.
REQ-015 out_ready  in  1  downstream accepts the output bit.
REQ-016 stuff_err  out  1  one-cycle pulse; destuff mode found a 1 where a stuffed 0 was required.
REQ-017 level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-018 Each FIFO entry stores {ptype, bit}. Push occurs when in_valid && in_ready; pop occurs as defined in REQ-021 and REQ-023.
REQ-019 full = (level == DEPTH); in_ready = ~full. Ready has no combinational path from out_ready. Push and pop in the same cycle leave level unchanged. Read and write pointers wrap modulo DEPTH.
REQ-020 Run counter run (4 bits): increments on each transferred or consumed data bit equal to 1; clears on a data bit equal to 0, on a stuff event, or when the head ptype differs from the last transferred ptype.
REQ-021 Stuff mode, run < RUN_LEN: out_valid = ~empty; out_bit and out_ptype come from the FIFO head; a pop occurs on out_valid && out_ready.
REQ-022 Stuff mode, run == RUN_LEN: out_valid = 1 even when the FIFO is empty; out_bit = 0; out_ptype = last transferred ptype; no pop; run clears on transfer.
REQ-023 Destuff mode, run < RUN_LEN: behaves as REQ-021. At run == RUN_LEN with the FIFO non-empty, the head is popped with out_valid = 0 and run clears. If the popped bit is 1, stuff_err pulses on the next cycle.
REQ-024 Latency: an input bit is visible at out_bit no earlier than 1 cycle after its push (registered FIFO); there is no input-to-output bypass.
REQ-025 Mode is latched into a mode_q register only when the FIFO is empty and no stuff is pending; changes at any other time are ignored until that condition holds.
REQ-026 flush takes priority over push and pop in the same cycle. After flush: level = 0, run = 0, out_valid = 0. A push coinciding with flush is dropped.
REQ-027 Output stability: while out_valid && ~out_ready, out_bit and out_ptype hold their values.

Reset
REQ-028 With rst asserted, asynchronously: level = 0, pointers = 0, run = 0, mode_q = 0, last ptype = 0, stuff_err = 0, out_valid = 0, in_ready = 1.
REQ-029 Reset asserted mid-packet discards all queued bits and any pending stuff; the first cycle after release behaves as idle.

Verification
REQ-030 Stuff mode, RUN_LEN=6, out_ready=1, push 8 ones with ptype=2 -> output 1,1,1,1,1,1,0,1,1, all with out_ptype=2.
REQ-031 Stuff mode, push exactly 6 ones then stop -> 7th output is 0 with out_valid=1 while level=0; out_valid then drops to 0.
REQ-032 Destuff mode, push 1x6,0,1 -> output 1x6,1; stuff_err stays 0. Push 1x7 instead -> output 1x6, and stuff_err pulses 1 cycle.
REQ-033 out_ready=0, push DEPTH bits -> level=DEPTH, in_ready=0. Then raise out_ready with in_valid=1 -> level holds at DEPTH minus pops plus pushes, and no bit is lost or duplicated.
REQ-034 Push 1x5 with ptype=1, then 1x3 with ptype=3 -> no stuff bit inserted, because the run clears at the ptype change.
REQ-035 Assert rst and then flush, each during a pending stuff -> outputs match REQ-028 and REQ-026, and the next packet is stuffed from run = 0.

Source files
------------

// File: rtl/bitstuff_gen.sv
// -----------------------------------------------------------------------------
// bitstuff_gen
//
// Serial bit-stuffing / destuffing engine with an input FIFO.
//
// Stuff mode (mode_q = 0): after RUN_LEN consecutive 1s of one packet type
// have left the block, a 0 is inserted. It carries the ptype of the run that
// caused it.
// Destuff mode (mode_q = 1): after RUN_LEN consecutive 1s have left the block,
// the next queued bit is consumed silently. If that bit is a 1 instead of the
// expected stuffed 0, stuff_err pulses for one cycle.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   mode       in   0 = stuff, 1 = destuff (latched only while idle)
//   flush      in   synchronous clear of FIFO, run counter and pending stuff
//   in_bit     in   serial data bit
//   in_ptype   in   packet-type tag of in_bit
//   in_valid   in   in_bit / in_ptype are valid
//   in_ready   out  FIFO not full
//   out_bit    out  serial output bit
//   out_ptype  out  packet-type tag of out_bit
//   out_valid  out  out_bit / out_ptype are valid
//   out_ready  in   downstream accepts the output bit
//   stuff_err  out  one-cycle pulse: destuff found a 1 where a 0 was stuffed
//   level      out  current FIFO occupancy
// -----------------------------------------------------------------------------
module bitstuff_gen #(
  parameter int RUN_LEN = 6,   // 2..15
  parameter int DEPTH   = 16,  // power of 2, >= 4
  parameter int PTYPE_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         flush,
  input  logic                         in_bit,
  input  logic [PTYPE_W-1:0]           in_ptype,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         out_bit,
  output logic [PTYPE_W-1:0]           out_ptype,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         stuff_err,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  // Each entry is {ptype, bit}.
  logic [PTYPE_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [3:0]           run_q, run_d;
  logic [PTYPE_W-1:0]   last_ptype_q, last_ptype_d;
  logic                 mode_q, mode_d;
  logic                 stuff_err_q, stuff_err_d;

  logic                 empty, full;
  logic                 run_hit;
  logic                 stuff_pend;
  logic                 discard;
  logic                 push, pop_data, pop;
  logic                 head_bit;
  logic [PTYPE_W-1:0]   head_ptype;

  assign empty      = (level_q == '0);
  assign full       = (level_q == LVL_W'(DEPTH));
  assign run_hit    = (run_q == 4'(RUN_LEN));
  assign head_bit   = mem_q[rd_ptr_q][0];
  assign head_ptype = mem_q[rd_ptr_q][PTYPE_W:1];

  // A completed run in stuff mode owes a 0 regardless of FIFO contents; it is
  // emitted before anything else so that a held output never changes value.
  assign stuff_pend = ~mode_q & run_hit;
  // A completed run in destuff mode swallows the next queued bit.
  assign discard    = mode_q & run_hit & ~empty;

  assign push     = in_valid & ~full;
  assign pop_data = ~run_hit & ~empty & out_ready;
  assign pop      = pop_data | discard;

  assign in_ready  = ~full;
  assign out_valid = stuff_pend | (~run_hit & ~empty);
  assign out_bit   = stuff_pend ? 1'b0 : head_bit;
  assign out_ptype = stuff_pend ? last_ptype_q : head_ptype;
  assign stuff_err = stuff_err_q;
  assign level     = level_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    run_d        = run_q;
    last_ptype_d = last_ptype_q;
    stuff_err_d  = 1'b0;
    // Mode may only change between packets: nothing queued, no stuff owed.
    mode_d       = (empty && !stuff_pend) ? mode : mode_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      run_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      if (stuff_pend) begin
        if (out_ready) run_d = '0;
      end else if (discard) begin
        run_d       = '0;
        stuff_err_d = head_bit;
      end else if (pop_data) begin
        last_ptype_d = head_ptype;
        // A new packet type starts a fresh run with its first bit.
        if (head_ptype != last_ptype_q) run_d = {3'b000, head_bit};
        else if (head_bit)              run_d = run_q + 4'd1;
        else                            run_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      run_q        <= '0;
      last_ptype_q <= '0;
      mode_q       <= 1'b0;
      stuff_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      run_q        <= run_d;
      last_ptype_q <= last_ptype_d;
      mode_q       <= mode_d;
      stuff_err_q  <= stuff_err_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers define which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {in_ptype, in_bit};
  end

endmodule
